// File: rtl/ssd_scanner.sv
// ssd_scanner: four-digit common-anode seven-segment display scanner.
//   Cycles through digits 0..3, giving each one CLK_DIV clock cycles. The first
//   BLANK_CYCLES of every slot keep all anodes off so segments can settle.
//   Display data is captured once per frame, at the first cycle of slot 0.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   ssd_bits      four display bytes, byte n -> digit n (digit 0 = rightmost)
//   ssd_char_mode 1 = bytes are character codes, 0 = raw segment patterns
//   seg           segment drive, active-low, seg[0..6] = a..g, seg[7] = dp
//   an            anode enables, active-low, an[n] drives digit n
module ssd_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ssd_bits,
  input  logic        ssd_char_mode,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [31:0]   snap_bits_q, snap_bits_d;
  logic          snap_mode_q, snap_mode_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          cnt_wrap;
  logic          frame_start;
  logic [7:0]    byte_sel;
  logic [6:0]    char_glyph;
  logic [7:0]    glyph;

  always_comb begin
    cnt_wrap    = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d       = cnt_wrap ? '0 : cnt_q + CW'(1);
    dig_d       = cnt_wrap ? dig_q + 2'd1 : dig_q;

    frame_start = (cnt_q == '0) && (dig_q == 2'd0);
    snap_bits_d = frame_start ? ssd_bits      : snap_bits_q;
    snap_mode_d = frame_start ? ssd_char_mode : snap_mode_q;

    // Outputs are built from the snapshot as it stood before this cycle's
    // latch; at frame start the anodes are blanked, so the stale glyph never shows.
    byte_sel = snap_bits_q[{dig_q, 3'b000} +: 8];

    char_glyph = 7'h00;
    case (byte_sel[6:0])
      7'h00: char_glyph = 7'h3F;
      7'h01: char_glyph = 7'h06;
      7'h02: char_glyph = 7'h5B;
      7'h03: char_glyph = 7'h4F;
      7'h04: char_glyph = 7'h66;
      7'h05: char_glyph = 7'h6D;
      7'h06: char_glyph = 7'h7D;
      7'h07: char_glyph = 7'h07;
      7'h08: char_glyph = 7'h7F;
      7'h09: char_glyph = 7'h6F;
      7'h0A: char_glyph = 7'h77;
      7'h0B: char_glyph = 7'h7C;
      7'h0C: char_glyph = 7'h39;
      7'h0D: char_glyph = 7'h5E;
      7'h0E: char_glyph = 7'h79;
      7'h0F: char_glyph = 7'h71;
      7'h11: char_glyph = 7'h40;
      7'h12: char_glyph = 7'h08;
      default: char_glyph = 7'h00;
    endcase

    glyph = snap_mode_q ? {byte_sel[7], char_glyph} : byte_sel;

    seg_d = ~glyph;
    // Blanking window at slot start guarantees a gap between successive anodes.
    an_d  = (cnt_q < CW'(BLANK_CYCLES)) ? 4'b1111 : ~(4'b0001 << dig_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      snap_bits_q <= '0;
      snap_mode_q <= 1'b0;
      seg_q       <= '1;
      an_q        <= '1;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      snap_bits_q <= snap_bits_d;
      snap_mode_q <= snap_mode_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
